multicycle_ctrl: RTL and testbench

- Multicycle control unit for the ARM-subset datapath (DP: ADD/SUB/AND/ORR/CMP; LDR/STR; B).
- Sequences one shared ALU and one unified memory over 3-5 cycles per instruction.
- Holds the NZCV flag register and the conditional-execution latch.
- Drives every datapath enable and mux select; sits beside the multicycle datapath as the replacement for the single-cycle control path.

---
 rtl/multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the ARM-subset datapath: sequences FETCH/DECODE/EXECUTE/MEM/WB, holds NZCV and the condition latch.
// Optional feature: define MULTICYCLE_CTRL_UNDEF_HALT_EN to trap Op=11 into a sticky HALT state.
module multicycle_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ALUControl,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic         RegWrite,
    output logic         Halted
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
`ifdef MULTICYCLE_CTRL_UNDEF_HALT_EN
        , S_HALT
`endif
    } state_e;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_is_pc;
    logic       is_cmp;
    logic       is_arith;
    logic [1:0] alu_op;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic       reg_write;

    // Rn is routed straight to the register file by the datapath.
    logic unused_rn;
    assign unused_rn = ^Instr[19:16];

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign is_cmp   = (cmd == CMD_CMP);
    assign is_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);

    function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = cy;
            4'b0011: cond_ex = ~cy;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = cy & ~z;
            4'b1001: cond_ex = ~cy | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    endfunction

    always_comb begin
        case (cmd)
            CMD_ADD: alu_op = 2'b00;
            CMD_SUB: alu_op = 2'b01;
            CMD_AND: alu_op = 2'b10;
            CMD_ORR: alu_op = 2'b11;
            CMD_CMP: alu_op = 2'b01;
            default: alu_op = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // CV survives logical ops; CMP updates flags even without the S bit.
    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;
        if (state_q == S_DECODE) begin
            cond_ex_d = cond_ex(cond, flags_q);
        end
        if ((state_q == S_EXECUTER || state_q == S_EXECUTEI) && cond_ex_q && (funct[0] || is_cmp)) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (is_arith) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 2'b00;
        reg_write   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_UNDEF_HALT_EN
                    default: state_d = S_HALT;
`else
                    default: state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex_q;
                pc_write   = cond_ex_q & rd_is_pc;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = cond_ex_q;
                state_d   = S_FETCH;
            end
            S_EXECUTER: begin
                alu_control = alu_op;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_b   = 2'b01;
                alu_control = alu_op;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = cond_ex_q & ~is_cmp;
                pc_write  = cond_ex_q & rd_is_pc & ~is_cmp;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex_q;
                state_d    = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_UNDEF_HALT_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Write enables are masked while reset is held so a mid-instruction abort never commits.
    assign PCWrite    = pc_write & ~reset;
    assign MemWrite   = mem_write & ~reset;
    assign IRWrite    = ir_write & ~reset;
    assign RegWrite   = reg_write & ~reset;
    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ALUControl = alu_control;
    assign ImmSrc     = op;
    assign RegSrc     = {op == 2'b01, op == 2'b10};

`ifdef MULTICYCLE_CTRL_UNDEF_HALT_EN
    assign Halted = (state_q == S_HALT);
`else
    assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors compared against hand-derived sequences.
// Observed vector: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, RegWrite, Halted}.
module tb_multicycle_ctrl;

    logic         clk;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, Halted;
    logic [1:0]   ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .Halted     (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [12:0] Z13      = 13'b0;
    localparam logic [12:0] S_F      = 13'b1_0_0_1_10_1_10_00_0_0;
    localparam logic [12:0] S_D      = 13'b0_0_0_0_10_1_10_00_0_0;
    localparam logic [12:0] S_MADR   = 13'b0_0_0_0_00_0_01_00_0_0;
    localparam logic [12:0] S_MRD    = 13'b0_1_0_0_00_0_00_00_0_0;
    localparam logic [12:0] S_HLT    = 13'b0_0_0_0_00_0_00_00_0_1;

    function automatic logic [12:0] s_memwb(input logic pcw, input logic rw);
        return {pcw, 3'b000, 2'b01, 1'b0, 2'b00, 2'b00, rw, 1'b0};
    endfunction
    function automatic logic [12:0] s_memwr(input logic mw);
        return {1'b0, 1'b1, mw, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
    endfunction
    function automatic logic [12:0] s_exr(input logic [1:0] alu);
        return {4'b0000, 2'b00, 1'b0, 2'b00, alu, 2'b00};
    endfunction
    function automatic logic [12:0] s_exi(input logic [1:0] alu);
        return {4'b0000, 2'b00, 1'b0, 2'b01, alu, 2'b00};
    endfunction
    function automatic logic [12:0] s_aluwb(input logic pcw, input logic rw);
        return {pcw, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, rw, 1'b0};
    endfunction
    function automatic logic [12:0] s_br(input logic pcw);
        return {pcw, 3'b000, 2'b10, 1'b0, 2'b01, 2'b00, 2'b00};
    endfunction

    // Holds one instruction on the inputs for n cycles, sampling outputs mid-cycle.
    task automatic play(input logic [19:0] instr, input logic [3:0] fl, input int n,
                        output logic [0:4][12:0] obs);
        obs = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            Instr    = instr;
            ALUFlags = fl;
            #1;
            obs[i] = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, ALUControl, RegWrite, Halted};
        end
    endtask

    task automatic test_reset();
        logic [0:4][12:0] obs, exp;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_enables[%0d]: got %b want 0000", c, {PCWrite, MemWrite, IRWrite, RegWrite});
            end
        end
        @(posedge clk);
        #2 reset = 1'b0;
        play(20'h0A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b0), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL reset_beq_flags0: got %h want %h", obs, exp); end
        play(20'h3A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b1), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL reset_bcc_flags0: got %h want %h", obs, exp); end
    endtask

    task automatic test_dp();
        logic [0:4][12:0] obs, exp;
        play(20'hE2821, 4'h0, 4, obs); exp = {S_F, S_D, s_exi(2'b00), s_aluwb(1'b0, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL add_imm: got %h want %h", obs, exp); end
        n_cmp++; if ({ImmSrc, RegSrc} !== 4'b0000) begin n_bad++; $display("FAIL dp_imm_reg_src: got %b want 0000", {ImmSrc, RegSrc}); end
        play(20'hE0421, 4'h0, 4, obs); exp = {S_F, S_D, s_exr(2'b01), s_aluwb(1'b0, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL sub_reg: got %h want %h", obs, exp); end
        play(20'hE0021, 4'h0, 4, obs); exp = {S_F, S_D, s_exr(2'b10), s_aluwb(1'b0, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL and_reg: got %h want %h", obs, exp); end
        play(20'hE3821, 4'h0, 4, obs); exp = {S_F, S_D, s_exi(2'b11), s_aluwb(1'b0, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL orr_imm: got %h want %h", obs, exp); end
        play(20'hE3A01, 4'h0, 4, obs); exp = {S_F, S_D, s_exi(2'b00), s_aluwb(1'b0, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL other_cmd: got %h want %h", obs, exp); end
        play(20'hE282F, 4'h0, 4, obs); exp = {S_F, S_D, s_exi(2'b00), s_aluwb(1'b1, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL add_pc: got %h want %h", obs, exp); end
    endtask

    task automatic test_mem();
        logic [0:4][12:0] obs, exp;
        play(20'hE5903, 4'h0, 5, obs); exp = {S_F, S_D, S_MADR, S_MRD, s_memwb(1'b0, 1'b1)};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL ldr: got %h want %h", obs, exp); end
        n_cmp++; if ({ImmSrc, RegSrc} !== 4'b0110) begin n_bad++; $display("FAIL mem_imm_reg_src: got %b want 0110", {ImmSrc, RegSrc}); end
        play(20'hE5803, 4'h0, 4, obs); exp = {S_F, S_D, S_MADR, s_memwr(1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL str: got %h want %h", obs, exp); end
        play(20'hE590F, 4'h0, 5, obs); exp = {S_F, S_D, S_MADR, S_MRD, s_memwb(1'b1, 1'b1)};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL ldr_pc: got %h want %h", obs, exp); end
    endtask

    task automatic test_flags_branch();
        logic [0:4][12:0] obs, exp;
        play(20'hE1510, 4'b0100, 4, obs); exp = {S_F, S_D, s_exr(2'b01), s_aluwb(1'b0, 1'b0), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL cmp: got %h want %h", obs, exp); end
        play(20'h0A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b1), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL beq_taken: got %h want %h", obs, exp); end
        n_cmp++; if ({ImmSrc, RegSrc} !== 4'b1001) begin n_bad++; $display("FAIL br_imm_reg_src: got %b want 1001", {ImmSrc, RegSrc}); end
        play(20'hE1510, 4'b0100, 4, obs);
        play(20'h1A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b0), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL bne_not_taken: got %h want %h", obs, exp); end
        // CMP sets C, then ANDS sets N and must leave C alone: NZCV = 1010.
        play(20'hE1510, 4'b0010, 4, obs);
        play(20'hE0121, 4'b1000, 4, obs); exp = {S_F, S_D, s_exr(2'b10), s_aluwb(1'b0, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL ands: got %h want %h", obs, exp); end
        play(20'h2A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b1), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL bcs_c_kept: got %h want %h", obs, exp); end
        play(20'h4A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b1), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL bmi_n_set: got %h want %h", obs, exp); end
        // Failed CMPEQ and non-S ADD must not touch flags.
        play(20'h01510, 4'b0100, 4, obs); exp = {S_F, S_D, s_exr(2'b01), s_aluwb(1'b0, 1'b0), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL cmpeq_failed: got %h want %h", obs, exp); end
        play(20'hE2821, 4'b0100, 4, obs);
        play(20'h1A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b1), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL bne_flags_kept: got %h want %h", obs, exp); end
        play(20'hBA000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b1), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL blt: got %h want %h", obs, exp); end
        play(20'hAA000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b0), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL bge: got %h want %h", obs, exp); end
        play(20'h8A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b1), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL bhi: got %h want %h", obs, exp); end
        play(20'hFA000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b0), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL bnv: got %h want %h", obs, exp); end
    endtask

    task automatic test_cond_fail();
        logic [0:4][12:0] obs, exp;
        play(20'h02821, 4'h0, 4, obs); exp = {S_F, S_D, s_exi(2'b00), s_aluwb(1'b0, 1'b0), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL addeq_failed: got %h want %h", obs, exp); end
        play(20'h42821, 4'h0, 4, obs); exp = {S_F, S_D, s_exi(2'b00), s_aluwb(1'b0, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL addmi_passed: got %h want %h", obs, exp); end
        play(20'h0590F, 4'h0, 5, obs); exp = {S_F, S_D, S_MADR, S_MRD, s_memwb(1'b0, 1'b0)};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL ldreq_failed: got %h want %h", obs, exp); end
        play(20'h05803, 4'h0, 4, obs); exp = {S_F, S_D, S_MADR, s_memwr(1'b0), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL streq_failed: got %h want %h", obs, exp); end
    endtask

    task automatic test_reset_mid();
        logic [0:4][12:0] obs, exp;
        play(20'hE590F, 4'h0, 4, obs);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_in_memwb: got %b want 0000", {PCWrite, MemWrite, IRWrite, RegWrite});
        end
        @(posedge clk);
        #2 reset = 1'b0;
        play(20'h4A000, 4'h0, 3, obs); exp = {S_F, S_D, s_br(1'b0), Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL bmi_after_abort: got %h want %h", obs, exp); end
    endtask

    task automatic test_undef();
        logic [0:4][12:0] obs, exp;
`ifdef MULTICYCLE_CTRL_UNDEF_HALT_EN
        play(20'hEC000, 4'h0, 5, obs); exp = {S_F, S_D, S_HLT, S_HLT, S_HLT};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL undef_halt: got %h want %h", obs, exp); end
        play(20'hE2821, 4'h0, 4, obs); exp = {S_HLT, S_HLT, S_HLT, S_HLT, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL halt_sticky: got %h want %h", obs, exp); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
`else
        play(20'hEC000, 4'h0, 2, obs); exp = {S_F, S_D, Z13, Z13, Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL undef_nop: got %h want %h", obs, exp); end
`endif
        play(20'hE2821, 4'h0, 4, obs); exp = {S_F, S_D, s_exi(2'b00), s_aluwb(1'b0, 1'b1), Z13};
        n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL after_undef: got %h want %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] prog [5] = '{20'hEA000, 20'hE2821, 20'hE5903, 20'hE5803, 20'hE1510};
        int          want [5] = '{3, 4, 5, 4, 4};
        int          lat;
        logic        found;
        @(negedge clk);
        Instr    = prog[0];
        ALUFlags = 4'h0;
        #1;
        n_cmp++;
        if (IRWrite !== 1'b1) begin n_bad++; $display("FAIL b2b_start: got IRWrite=%b want 1", IRWrite); end
        for (int k = 0; k < 5; k++) begin
            lat   = 1;
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                Instr = prog[k];
                #1;
                if (IRWrite === 1'b1) found = 1'b1;
                else lat++;
            end
            n_cmp++;
            if (!found || lat != want[k]) begin
                n_bad++;
                $display("FAIL b2b_latency[%0d]: got %0d cycles (found=%b) want %0d", k, lat, found, want[k]);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = '0;
        ALUFlags = 4'h0;
        test_reset();
        test_dp();
        test_mem();
        test_flags_branch();
        test_cond_fail();
        test_reset_mid();
        test_undef();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
